// File: rtl/brick_collision_pkg.sv
// Shared brick-wall geometry, FSM state codes and coordinate helpers for the
// brick collision block and anything else that draws or tests the wall.
package brick_collision_pkg;

  localparam int BRICK_COLS = 8;
  localparam int BRICK_ROWS = 4;
  localparam int N_BRICKS   = BRICK_COLS * BRICK_ROWS;
  localparam int IDX_W      = $clog2(N_BRICKS);
  localparam int BRICK_W    = 64;
  localparam int BRICK_H    = 16;
  localparam int WALL_X0    = 64;
  localparam int WALL_Y0    = 48;
  localparam int BALL_R     = 8;
  localparam int PADDLE_Y   = 440;
  localparam int PADDLE_H   = 8;
  localparam int PADDLE_HW  = 32;

  // Scan sequencer states.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETTLE = 3'd1;
  localparam logic [2:0] ST_SCAN   = 3'd2;
  localparam logic [2:0] ST_PADDLE = 3'd3;
  localparam logic [2:0] ST_REPORT = 3'd4;

  // Which bounce the ball controller must take this frame.
  typedef enum logic [1:0] {
    KIND_NONE = 2'd0,
    KIND_H    = 2'd1,
    KIND_V    = 2'd2
  } hit_kind_t;

  // Signed screen coordinate, wide enough that neither pos-R nor pos+R wraps.
  typedef logic signed [11:0] coord_t;

  localparam coord_t C_BALL_R       = coord_t'(BALL_R);
  localparam coord_t C_BRICK_W      = coord_t'(BRICK_W);
  localparam coord_t C_BRICK_H      = coord_t'(BRICK_H);
  localparam coord_t C_PADDLE_Y     = coord_t'(PADDLE_Y);
  localparam coord_t C_PADDLE_BOT   = coord_t'(PADDLE_Y + PADDLE_H);
  localparam coord_t C_PADDLE_REACH = coord_t'(PADDLE_HW + BALL_R);

  function automatic coord_t to_coord(input logic [9:0] v);
    return coord_t'({2'b00, v});
  endfunction

endpackage

// File: rtl/brick_collision_if.sv
// Signal bundle between the ball controller / renderer side and the brick
// collision block.
interface brick_collision_if;
  import brick_collision_pkg::*;

  logic                vsync;
  logic [9:0]          ball_x;
  logic [9:0]          ball_y;
  logic [9:0]          paddle_x;
  logic                new_game;
  logic                h_collision;
  logic                v_collision;
  logic [N_BRICKS-1:0] brick_alive;
  logic [7:0]          score;
  logic                all_cleared;
  logic                busy;

  modport master (
    output vsync, ball_x, ball_y, paddle_x, new_game,
    input  h_collision, v_collision, brick_alive, score, all_cleared, busy
  );

  modport slave (
    input  vsync, ball_x, ball_y, paddle_x, new_game,
    output h_collision, v_collision, brick_alive, score, all_cleared, busy
  );
endinterface

// File: rtl/brick_overlap.sv
// Combinational test of the ball bounding box against one brick, chosen by
// its linear index (row*COLS + col).
module brick_overlap
  import brick_collision_pkg::*;
(
  input  logic [9:0]       bx,
  input  logic [9:0]       by,
  input  logic [IDX_W-1:0] idx,
  output logic             overlap,
  output logic             center_in_x
);

  int     col_i;
  int     row_i;
  coord_t x0, x1, y0, y1, sx, sy;

  // Derive brick bounds from the index and compare against the ball box.
  always_comb begin
    col_i = int'(idx) % BRICK_COLS;
    row_i = int'(idx) / BRICK_COLS;
    x0 = coord_t'(WALL_X0 + col_i * BRICK_W);
    y0 = coord_t'(WALL_Y0 + row_i * BRICK_H);
    x1 = x0 + C_BRICK_W;
    y1 = y0 + C_BRICK_H;
    sx = to_coord(bx);
    sy = to_coord(by);
    overlap = (sx + C_BALL_R > x0) && (sx - C_BALL_R < x1) &&
              (sy + C_BALL_R > y0) && (sy - C_BALL_R < y1);
    // Ball centre within the brick's columns means it came in from above/below.
    center_in_x = (sx >= x0) && (sx < x1);
  end

endmodule

// File: rtl/brick_collision.sv
// Brick wall state, score and per-frame collision scan. One brick is tested
// per pixel clock after each vsync rise, then the paddle, then a single
// one-cycle bounce pulse is reported to the ball controller.
module brick_collision
  import brick_collision_pkg::*;
(
  input  logic        pxl_clk,
  input  logic        reset_n,
  brick_collision_if.slave bus
);

  logic [2:0]          state;
  logic                vsync_d;
  logic                rise;
  logic [9:0]          bx, by, px, prev_y;
  logic [IDX_W-1:0]    idx;
  hit_kind_t           kind;
  logic [N_BRICKS-1:0] alive;
  logic [7:0]          score;
  logic                all_clr;
  logic                h_col, v_col;
  logic                overlap, center_in_x;
  logic                paddle_hit;
  coord_t              dx_c, dx_abs, dy_c;

  assign rise = bus.vsync & ~vsync_d;

  brick_overlap u_overlap (
    .bx          (bx),
    .by          (by),
    .idx         (idx),
    .overlap     (overlap),
    .center_in_x (center_in_x)
  );

  // Paddle hit: ball moving down and its box touching the paddle strip.
  always_comb begin
    dx_c   = to_coord(bx) - to_coord(px);
    dx_abs = dx_c[11] ? -dx_c : dx_c;
    dy_c   = to_coord(by);
    paddle_hit = (by > prev_y) &&
                 (dy_c + C_BALL_R >= C_PADDLE_Y) &&
                 (dy_c - C_BALL_R < C_PADDLE_BOT) &&
                 (dx_abs < C_PADDLE_REACH);
  end

  // Frame sequencer, wall/score state and registered bounce pulses.
  always_ff @(posedge pxl_clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      vsync_d <= 1'b0;
      bx      <= '0;
      by      <= '0;
      px      <= '0;
      prev_y  <= '0;
      idx     <= '0;
      kind    <= KIND_NONE;
      alive   <= '1;
      score   <= '0;
      all_clr <= 1'b0;
      h_col   <= 1'b0;
      v_col   <= 1'b0;
    end else begin
      vsync_d <= bus.vsync;
      h_col   <= 1'b0;
      v_col   <= 1'b0;
      all_clr <= (alive == '0);
      if (bus.new_game) begin
        // Restart wins over any scan in flight; no pulse for the aborted frame.
        alive   <= '1;
        score   <= '0;
        all_clr <= 1'b0;
        state   <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (rise) state <= ST_SETTLE;
          end
          ST_SETTLE: begin
            // Ball moved on the rise cycle; its position is stable now.
            bx    <= bus.ball_x;
            by    <= bus.ball_y;
            px    <= bus.paddle_x;
            kind  <= KIND_NONE;
            idx   <= '0;
            state <= ST_SCAN;
          end
          ST_SCAN: begin
            if (kind == KIND_NONE && alive[idx] && overlap) begin
              alive[idx] <= 1'b0;
              if (score != 8'hFF) score <= score + 8'd1;
              kind <= center_in_x ? KIND_V : KIND_H;
            end
            if (idx == IDX_W'(N_BRICKS - 1)) state <= ST_PADDLE;
            else idx <= idx + 1'b1;
          end
          ST_PADDLE: begin
            v_col  <= (kind == KIND_V) || (kind == KIND_NONE && paddle_hit);
            h_col  <= (kind == KIND_H);
            prev_y <= by;
            state  <= ST_REPORT;
          end
          ST_REPORT: begin
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.h_collision = h_col;
  assign bus.v_collision = v_col;
  assign bus.brick_alive = alive;
  assign bus.score       = score;
  assign bus.all_cleared = all_clr;
  assign bus.busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_brick_collision.sv
// Self-checking bench for brick_collision: directed frames plus randomized
// ball/paddle positions, checked every cycle against a behavioural model.
module tb_brick_collision;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  brick_collision_if bus();

  brick_collision dut (
    .pxl_clk (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // Model state and per-cycle expectations.
  logic [31:0] m_alive = '1;
  int m_score = 0;
  int m_prev_y = 0;
  int exp_pulse_cyc = -1;
  int exp_kind = 0;
  int busy_lo = 1;
  int busy_hi = 0;
  bit state_valid = 1'b1;
  bit run_cmp = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // One frame of the game rules: first live brick touched wins, else paddle.
  // Returns 0 = no bounce, 1 = side bounce, 2 = top/bottom bounce.
  function automatic int model_frame(input int bx, input int by, input int px);
    int k;
    k = 0;
    for (int i = 0; i < 32; i++) begin
      int x0, y0;
      x0 = 64 + (i % 8) * 64;
      y0 = 48 + (i / 8) * 16;
      if (k == 0 && m_alive[i] && bx + 8 > x0 && bx - 8 < x0 + 64 &&
          by + 8 > y0 && by - 8 < y0 + 16) begin
        m_alive[i] = 1'b0;
        if (m_score < 255) m_score++;
        k = (bx >= x0 && bx < x0 + 64) ? 2 : 1;
      end
    end
    if (k == 0 && by > m_prev_y && by + 8 >= 440 && by - 8 < 448 && iabs(bx - px) < 40)
      k = 2;
    m_prev_y = by;
    return k;
  endfunction

  function automatic void model_wall_reset();
    m_alive = '1;
    m_score = 0;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Per-cycle comparison of every output against the model.
  initial forever begin
    @(negedge clk);
    if (run_cmp) begin
      chk("h_collision", bus.h_collision, (cyc == exp_pulse_cyc && exp_kind == 1));
      chk("v_collision", bus.v_collision, (cyc == exp_pulse_cyc && exp_kind == 2));
      chk("busy", bus.busy, (cyc >= busy_lo && cyc <= busy_hi));
      if (state_valid) begin
        chk("brick_alive", bus.brick_alive, m_alive);
        chk("score", bus.score, m_score);
        chk("all_cleared", bus.all_cleared, (m_alive == 32'h0));
      end
    end
  end

  // Runs one vsync frame; all tasks start and end at posedge+1.
  task automatic frame(input int bx, input int by, input int px, input bit mid_rise,
                       output int k, output int nh, output int nv);
    int rc;
    nh = 0;
    nv = 0;
    bus.ball_x = 10'(bx);
    bus.ball_y = 10'(by);
    bus.paddle_x = 10'(px);
    state_valid = 1'b0;
    k = model_frame(bx, by, px);
    rc = cyc;
    exp_kind = k;
    exp_pulse_cyc = rc + 35;
    busy_lo = rc + 1;
    busy_hi = rc + 35;
    bus.vsync = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (cyc == rc + 2) bus.vsync = 1'b0;
      if (mid_rise && cyc == rc + 10) bus.vsync = 1'b1;
      if (mid_rise && cyc == rc + 12) bus.vsync = 1'b0;
      if (bus.h_collision) nh++;
      if (bus.v_collision) nv++;
    end
    state_valid = 1'b1;
  endtask

  task automatic do_new_game();
    bus.new_game = 1'b1;
    state_valid = 1'b0;
    model_wall_reset();
    @(posedge clk);
    #1;
    bus.new_game = 1'b0;
    state_valid = 1'b1;
    chk("ng_alive", bus.brick_alive, 64'hFFFFFFFF);
    chk("ng_score", bus.score, 0);
    chk("ng_all_cleared", bus.all_cleared, 0);
  endtask

  // Starts a frame with a hit pending, then kills it at scan index 10.
  task automatic abort_frame(input int bx, input int by, input int px, input bit use_reset,
                             output int npulse);
    int rc, saved_prev, k;
    npulse = 0;
    bus.ball_x = 10'(bx);
    bus.ball_y = 10'(by);
    bus.paddle_x = 10'(px);
    state_valid = 1'b0;
    saved_prev = m_prev_y;
    k = model_frame(bx, by, px);
    rc = cyc;
    exp_kind = k;
    exp_pulse_cyc = rc + 35;
    busy_lo = rc + 1;
    busy_hi = rc + 35;
    bus.vsync = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (cyc == rc + 2) bus.vsync = 1'b0;
    end
    chk("abort_busy_mid_scan", bus.busy, 1);
    chk("abort_brick_cleared", bus.brick_alive, m_alive);
    exp_pulse_cyc = -1;
    if (use_reset) begin
      reset_n = 1'b0;
      model_wall_reset();
      m_prev_y = 0;
      busy_hi = rc + 11;
      state_valid = 1'b1;
      #1;
      chk("rst_alive", bus.brick_alive, 64'hFFFFFFFF);
      chk("rst_score", bus.score, 0);
      chk("rst_busy", bus.busy, 0);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
    end else begin
      bus.new_game = 1'b1;
      m_prev_y = saved_prev;
      model_wall_reset();
      busy_hi = rc + 12;
      @(posedge clk);
      #1;
      bus.new_game = 1'b0;
      state_valid = 1'b1;
      chk("ngab_alive", bus.brick_alive, 64'hFFFFFFFF);
      chk("ngab_score", bus.score, 0);
      chk("ngab_busy", bus.busy, 0);
    end
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (bus.h_collision || bus.v_collision) npulse++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int k, nh, nv, np;
    bus.vsync = 1'b0;
    bus.ball_x = '0;
    bus.ball_y = '0;
    bus.paddle_x = '0;
    bus.new_game = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    run_cmp = 1'b1;
    chk("reset_alive", bus.brick_alive, 64'hFFFFFFFF);
    chk("reset_score", bus.score, 0);
    chk("reset_pulses", {bus.h_collision, bus.v_collision, bus.busy, bus.all_cleared}, 0);

    // Top hit on brick 0.
    frame(96, 70, 320, 1'b0, k, nh, nv);
    $display("t1 ball(96,70) kind=%0d h=%0d v=%0d score=%0d", k, nh, nv, bus.score);
    chk("t1_model_kind", k, 2);
    chk("t1_v_pulses", nv, 1);
    chk("t1_h_pulses", nh, 0);
    chk("t1_brick0", bus.brick_alive[0], 0);
    chk("t1_score", bus.score, 1);
    do_new_game();

    // Side hit on brick 0, then the same position again finds nothing.
    frame(60, 56, 320, 1'b0, k, nh, nv);
    $display("t2 ball(60,56) kind=%0d h=%0d v=%0d score=%0d", k, nh, nv, bus.score);
    chk("t2_model_kind", k, 1);
    chk("t2_h_pulses", nh, 1);
    chk("t2_brick0", bus.brick_alive[0], 0);
    frame(60, 56, 320, 1'b0, k, nh, nv);
    $display("t2b ball(60,56) kind=%0d h=%0d v=%0d score=%0d", k, nh, nv, bus.score);
    chk("t2b_pulses", nh + nv, 0);
    chk("t2b_score", bus.score, 1);
    do_new_game();

    // Ball straddling bricks 0 and 1: only brick 0 goes.
    frame(128, 56, 320, 1'b0, k, nh, nv);
    $display("t3 ball(128,56) kind=%0d h=%0d v=%0d score=%0d", k, nh, nv, bus.score);
    chk("t3_model_kind", k, 1);
    chk("t3_pulses", nh + nv, 1);
    chk("t3_bricks01", bus.brick_alive[1:0], 2'b10);
    chk("t3_score", bus.score, 1);

    // Paddle: moving down hits, moving up does not.
    frame(320, 426, 320, 1'b0, k, nh, nv);
    chk("t4a_pulses", nh + nv, 0);
    frame(320, 436, 320, 1'b0, k, nh, nv);
    $display("t4 paddle down kind=%0d h=%0d v=%0d", k, nh, nv);
    chk("t4b_v_pulses", nv, 1);
    chk("t4b_h_pulses", nh, 0);
    frame(320, 436, 320, 1'b0, k, nh, nv);
    chk("t4c_pulses", nh + nv, 0);
    frame(320, 426, 320, 1'b0, k, nh, nv);
    $display("t4 paddle up h=%0d v=%0d", nh, nv);
    chk("t4d_pulses", nh + nv, 0);

    // Clear the whole wall, one brick per frame at its centre.
    do_new_game();
    for (int i = 0; i < 32; i++) begin
      frame(96 + (i % 8) * 64, 56 + (i / 8) * 16, 320, 1'b0, k, nh, nv);
      $display("t5 brick %0d kind=%0d h=%0d v=%0d score=%0d", i, k, nh, nv, bus.score);
    end
    chk("t5_score", bus.score, 32);
    chk("t5_all_cleared", bus.all_cleared, 1);
    chk("t5_alive", bus.brick_alive, 0);
    do_new_game();

    // Kill a scan with brick 3 already hit: async reset, then new_game.
    abort_frame(288, 56, 320, 1'b1, np);
    $display("t6 reset abort pulses=%0d", np);
    chk("t6_reset_no_pulse", np, 0);
    abort_frame(288, 56, 320, 1'b0, np);
    $display("t6 new_game abort pulses=%0d", np);
    chk("t6_ng_no_pulse", np, 0);

    // Randomized frames, biased toward bricks and the paddle.
    for (int f = 0; f < 80; f++) begin
      int bx, by, px, sel, b;
      bit mr;
      sel = int'($urandom_range(0, 3));
      b = int'($urandom_range(0, 31));
      px = int'($urandom_range(40, 600));
      if (sel == 0) begin
        bx = int'($urandom_range(0, 639));
        by = int'($urandom_range(0, 479));
      end else if (sel == 3) begin
        bx = px - 50 + int'($urandom_range(0, 100));
        by = 420 + int'($urandom_range(0, 30));
      end else begin
        bx = 52 + (b % 8) * 64 + int'($urandom_range(0, 87));
        by = 36 + (b / 8) * 16 + int'($urandom_range(0, 39));
      end
      mr = ($urandom_range(0, 3) == 0);
      frame(bx, by, px, mr, k, nh, nv);
      $display("rnd %0d ball(%0d,%0d) paddle %0d kind=%0d h=%0d v=%0d score=%0d",
               f, bx, by, px, k, nh, nv, bus.score);
      if (f % 25 == 24) do_new_game();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/brick_collision.md
Name: brick_collision

Overview:
- Produces the h_collision / v_collision inputs that the ball controller consumes.
- Holds the breakout brick wall state and, once per frame after the ball moves, scans every live brick and the paddle against the ball bounding box.
- Clears the brick that was hit, keeps the score, and emits one-pxl_clk collision pulses.
- Sits between the ball controller (ball_x/ball_y source) and the renderer (brick_alive, score consumer).

Parameters:
- BRICK_COLS, 8, bricks per row
- BRICK_ROWS, 4, brick rows; N = ROWS*COLS = 32
- BRICK_W, 64, brick width in px
- BRICK_H, 16, brick height in px
- WALL_X0, 64, x of brick column 0 left edge
- WALL_Y0, 48, y of brick row 0 top edge
- BALL_R, 8, ball half-size in px
- PADDLE_Y, 440, paddle top edge y
- PADDLE_HW, 32, paddle half-width in px

Ports:
- pxl_clk  in  1  pixel clock
- reset_n  in  1  async active-low reset
- vsync  in  1  frame sync, same signal the ball controller uses
- ball_x  in  10  ball centre x
- ball_y  in  10  ball centre y
- paddle_x  in  10  paddle centre x
- new_game  in  1  sync pulse: restore wall, zero score
- h_collision  out  1  one-cycle pulse, side hit
- v_collision  out  1  one-cycle pulse, top/bottom hit
- brick_alive  out  N  bit i = brick i present; i = row*COLS + col
- score  out  8  bricks destroyed, saturates at 255
- all_cleared  out  1  high when brick_alive == 0
- busy  out  1  scan in progress

Behaviour:
- Interface: reset reset_n, asynchronous, active-low; clock pxl_clk. All state is on posedge pxl_clk.
- Reset values: brick_alive all ones; score 0; h_collision, v_collision, busy, all_cleared 0; FSM in IDLE; prev_y 0.
- vsync is registered as vsync_d. rise = vsync & ~vsync_d.
- FSM states: IDLE, SETTLE, SCAN, PADDLE, REPORT.
  - IDLE: on rise, go to SETTLE. The ball moves on the first vsync-high cycle, so position is stable one cycle later.
  - SETTLE (1 cycle): latch bx = ball_x, by = ball_y, px = paddle_x. Clear the hit flag. Set idx = 0. Go to SCAN. busy = 1 from SETTLE through REPORT.
  - SCAN (N cycles, one brick per cycle, idx 0..N-1):
    - Brick i spans x [WALL_X0 + col*BRICK_W, +BRICK_W) and y [WALL_Y0 + row*BRICK_H, +BRICK_H).
    - Overlap test: bx+R > x0, bx-R < x1, by+R > y0, by-R < y1.
    - Compute in 11-bit signed arithmetic so bx-R never wraps.
    - On the first live overlapping brick only: clear its alive bit, increment score (saturating), record the kind.
      - kind = V if x0 <= bx < x1.
      - kind = H otherwise.
    - All later overlaps in the same frame are ignored.
    - After idx = N-1, go to PADDLE.
  - PADDLE (1 cycle): only if no brick hit this frame.
    - Condition: by > prev_y (moving down), by+R >= PADDLE_Y, by-R < PADDLE_Y+8, and |bx - px| < PADDLE_HW + R.
    - If all true, kind = V.
    - prev_y <= by unconditionally.
  - REPORT (1 cycle): assert exactly one of v_collision / h_collision per the recorded kind, or neither. Both low in every other cycle. Return to IDLE.
- Total latency from vsync rise to pulse: N+3 cycles. Must complete well within the vsync-low-to-next-vsync interval.
- A pulse is exactly 1 cycle, so the ball state machine takes exactly one bounce per hit. h and v are never asserted together.
- rise while not in IDLE: ignored.
- new_game: takes priority over everything.
  - Next cycle: brick_alive all ones, score 0, FSM to IDLE, no pulse.
  - If asserted mid-scan, the scan aborts.
- all_cleared is registered, equal to (brick_alive == 0), updated the cycle after the last clear.
- Async reset mid-scan: immediate return to reset values; no pulse afterwards.
- Wall edges are not handled here; the ball controller owns them.

Decomposition:
- Brick geometry constants (WALL_X0, WALL_Y0, BRICK_W/H, COLS/ROWS, PADDLE_Y, BALL_R) go in defines.v beside the screen edges, so the renderer shares them.
- Sub-module brick_overlap (combinational):
  - Inputs: bx, by, idx.
  - Outputs: overlap, center_in_x.
  - Computes brick bounds from idx.
  - Instantiated once and fed by the SCAN counter.

Test Plan:
1. Reset, then vsync rise with ball (96,70) → at cycle rise+35 v_collision pulses 1 cycle; brick_alive[0] = 0; score = 1; h_collision stays 0.
2. Ball (60,56) → h_collision pulse; brick 0 cleared. Repeat the frame at the same position → no pulse, score unchanged.
3. Ball overlapping bricks 0 and 1 at (128,56) → only brick 0 cleared; single pulse; score +1.
4. paddle_x = 320, ball (320,426) then (320,436) on consecutive frames → v_collision on the second frame. Same positions in reverse order (moving up) → no pulse.
5. Clear all 32 bricks over 32 frames → all_cleared = 1, score = 32. Then new_game → brick_alive = 0xFFFFFFFF, score = 0, all_cleared = 0.
6. Assert reset_n = 0 at SCAN idx 10 with a hit pending → outputs return to reset values at once; no pulse afterwards. new_game mid-scan behaves the same except state restores synchronously.
